// File: rtl/video_capture.sv
// RGB111 pixel-stream receiver: rebuilds frame/line structure from vsync and
// active, tracks lock against WIDTH x HEIGHT, and emits framebuffer writes.
module video_capture #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int AWIDTH = 19,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              red,
  input  logic              grn,
  input  logic              blu,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              active,
  input  logic              enable,
  output logic [AWIDTH-1:0] waddr,
  output logic [2:0]        wdata,
  output logic              we,
  output logic              frame,
  output logic              locked,
  output logic [10:0]       line_len
);

  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [10:0]       WIDTH_X  = 11'(WIDTH);
  localparam logic [YW-1:0]     HEIGHT_Y = YW'(HEIGHT);
  localparam logic [AWIDTH-1:0] WIDTH_A  = AWIDTH'(WIDTH);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    WAIT_DE = 2'd1,
    LINE    = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        s_rgb_q, s_rgb_d;
  logic              s_hs_q, s_hs_d, s_vs_q, s_vs_d, s_de_q, s_de_d;
  logic              p_vs_q, p_vs_d, p_de_q, p_de_d;
  logic [10:0]       x_q, x_d, cnt_q, cnt_d;
  logic [YW-1:0]     y_q, y_d;
  logic [AWIDTH-1:0] line_base_q, line_base_d;
  logic              cap_q, cap_d, line_bad_q, line_bad_d, frame_bad_q, frame_bad_d;
  logic              skip_chk_q, skip_chk_d, locked_q, locked_d;
  logic [1:0]        good_cnt_q, good_cnt_d;
  logic [10:0]       line_len_q, line_len_d;
  logic              we_q, we_d, frame_q, frame_d;
  logic [AWIDTH-1:0] waddr_q, waddr_d;
  logic [2:0]        wdata_q, wdata_d;

  logic              vs_start, de_rise, de_fall, frame_good, pix_go, cap_cur;
  logic [10:0]       x_cur, cnt_cur;
  logic [YW-1:0]     y_cur;
  logic [AWIDTH-1:0] base_cur;

  // Sync inputs are normalised to active-high as they are captured.
  always_comb begin
    s_rgb_d = {red, grn, blu};
    s_hs_d  = (hsync == HS_POL);
    s_vs_d  = (vsync == VS_POL);
    s_de_d  = active;
    p_vs_d  = s_vs_q;
    p_de_d  = s_de_q;
  end

  assign vs_start = s_vs_q & ~p_vs_q;
  assign de_rise  = s_de_q & ~p_de_q;
  assign de_fall  = ~s_de_q & p_de_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    line_base_d = line_base_q;
    cap_d       = cap_q;
    line_bad_d  = line_bad_q;
    frame_bad_d = frame_bad_q;
    skip_chk_d  = skip_chk_q;
    good_cnt_d  = good_cnt_q;
    locked_d    = locked_q;
    line_len_d  = line_len_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    frame_d     = 1'b0;
    pix_go      = 1'b0;
    x_cur       = x_q;
    cnt_cur     = cnt_q;
    y_cur       = y_q;
    base_cur    = line_base_q;
    cap_cur     = cap_q;
    frame_good  = (y_q == HEIGHT_Y) && !line_bad_q && !frame_bad_q;

    if (vs_start) begin
      // Frame restart wins over any line activity; a coincident pixel is x=0,y=0.
      frame_d     = 1'b1;
      cap_d       = enable;
      x_d         = 11'd0;
      cnt_d       = 11'd0;
      y_d         = '0;
      line_base_d = '0;
      line_bad_d  = 1'b0;
      frame_bad_d = 1'b0;
      skip_chk_d  = 1'b0;
      x_cur       = 11'd0;
      cnt_cur     = 11'd0;
      y_cur       = '0;
      base_cur    = '0;
      cap_cur     = enable;
      if (skip_chk_q) begin
        good_cnt_d = good_cnt_q;
      end else if (frame_good) begin
        good_cnt_d = (good_cnt_q == 2'd2) ? 2'd2 : good_cnt_q + 2'd1;
        locked_d   = (good_cnt_q != 2'd0);
      end else begin
        good_cnt_d = 2'd0;
        locked_d   = 1'b0;
      end
      if (s_de_q) begin
        pix_go  = 1'b1;
        state_d = LINE;
      end else begin
        state_d = WAIT_DE;
      end
    end else begin
      case (state_q)
        SEARCH: state_d = SEARCH;
        WAIT_DE, GAP: begin
          if (de_rise) begin
            pix_go  = 1'b1;
            x_cur   = 11'd0;
            cnt_cur = 11'd0;
            state_d = LINE;
          end else begin
            state_d = state_q;
          end
        end
        LINE: begin
          if (de_fall) begin
            line_len_d = cnt_q;
            if (cnt_q != WIDTH_X) begin
              line_bad_d = 1'b1;
            end else begin
              line_bad_d = line_bad_q;
            end
            if (y_q < HEIGHT_Y) begin
              y_d         = y_q + YW'(1);
              line_base_d = line_base_q + WIDTH_A;
            end else begin
              y_d = y_q;
            end
            state_d = GAP;
          end else if (s_de_q) begin
            pix_go = 1'b1;
          end else begin
            state_d = LINE;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    // hsync asserted inside active video means wrong polarity or broken timing.
    if (pix_go) begin
      cnt_d = (cnt_cur == 11'h7FF) ? cnt_cur : cnt_cur + 11'd1;
      if (y_cur >= HEIGHT_Y) begin
        frame_bad_d = 1'b1;
      end else if (x_cur >= WIDTH_X) begin
        line_bad_d = 1'b1;
      end else begin
        x_d = x_cur + 11'd1;
        if (s_hs_q) begin
          line_bad_d = 1'b1;
        end else begin
          line_bad_d = line_bad_d;
        end
        if (cap_cur) begin
          we_d    = 1'b1;
          waddr_d = base_cur + AWIDTH'(x_cur);
          wdata_d = s_rgb_q;
        end else begin
          we_d = 1'b0;
        end
      end
    end else begin
      we_d = 1'b0;
    end
  end

  // Sync flags reset as "already active" so a level held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      s_rgb_q     <= 3'd0;
      s_hs_q      <= 1'b0;
      s_vs_q      <= 1'b1;
      s_de_q      <= 1'b0;
      p_vs_q      <= 1'b1;
      p_de_q      <= 1'b0;
      x_q         <= 11'd0;
      cnt_q       <= 11'd0;
      y_q         <= '0;
      line_base_q <= '0;
      cap_q       <= 1'b0;
      line_bad_q  <= 1'b0;
      frame_bad_q <= 1'b0;
      skip_chk_q  <= 1'b1;
      good_cnt_q  <= 2'd0;
      locked_q    <= 1'b0;
      line_len_q  <= 11'd0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= 3'd0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_rgb_q     <= s_rgb_d;
      s_hs_q      <= s_hs_d;
      s_vs_q      <= s_vs_d;
      s_de_q      <= s_de_d;
      p_vs_q      <= p_vs_d;
      p_de_q      <= p_de_d;
      x_q         <= x_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      line_base_q <= line_base_d;
      cap_q       <= cap_d;
      line_bad_q  <= line_bad_d;
      frame_bad_q <= frame_bad_d;
      skip_chk_q  <= skip_chk_d;
      good_cnt_q  <= good_cnt_d;
      locked_q    <= locked_d;
      line_len_q  <= line_len_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      frame_q     <= frame_d;
    end
  end

  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign we       = we_q;
  assign frame    = frame_q;
  assign locked   = locked_q;
  assign line_len = line_len_q;

endmodule

// File: tb/tb_video_capture.sv
// Table-driven bench for video_capture on a reduced 8x4 raster: each record
// describes one frame to drive and the counts/flags it must produce.
module tb_video_capture;

  localparam int TW = 8;
  localparam int TH = 4;
  localparam int TA = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          red = 1'b0, grn = 1'b0, blu = 1'b0;
  logic          hsync = 1'b1, vsync = 1'b1, active = 1'b0, enable = 1'b0;
  logic [TA-1:0] waddr;
  logic [2:0]    wdata;
  logic          we, frame, locked;
  logic [10:0]   line_len;

  video_capture #(.WIDTH(TW), .HEIGHT(TH), .AWIDTH(TA), .HS_POL(1'b0), .VS_POL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .red(red), .grn(grn), .blu(blu),
    .hsync(hsync), .vsync(vsync), .active(active), .enable(enable),
    .waddr(waddr), .wdata(wdata), .we(we), .frame(frame), .locked(locked),
    .line_len(line_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic vs_de;
    int   nlines;
    int   odd_line;
    int   odd_len;
    int   rst_line;
    logic lock_start;
    int   writes;
    int   max_addr;
    int   len_last;
  } frame_rec_t;

  frame_rec_t tbl [17];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int max_addr = -1;
  int last_addr = -1;
  int vs_cyc = 0;
  int frame_cyc = -100;
  int frame_seen = 0;
  int lock_at_frame = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] pat(input int ln, input int x);
    int v;
    v = (ln * 3 + x) & 7;
    return v[2:0];
  endfunction

  function automatic logic [2:0] pat_addr(input int a);
    return pat(a / TW, a % TW);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame) begin
      frame_seen    = 1;
      frame_cyc     = cyc;
      lock_at_frame = int'(locked);
      last_addr     = -1;
    end
    if (we) begin
      wr_cnt++;
      if (int'(waddr) > max_addr) max_addr = int'(waddr);
      chk("waddr_range", int'(int'(waddr) <= TW * TH - 1), 1);
      chk("waddr_monotonic", int'(int'(waddr) > last_addr), 1);
      chk("wdata", int'(wdata), int'(pat_addr(int'(waddr))));
      last_addr = int'(waddr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input frame_rec_t r);
    int len;
    vsync = 1'b1; active = 1'b0; hsync = 1'b1;
    repeat (3) step();
    wr_cnt = 0; max_addr = -1; frame_seen = 0;
    vsync  = 1'b0;
    enable = r.en;
    if (!r.vs_de) begin
      step();
      vs_cyc = cyc;
      step();
      vsync = 1'b1;
      step();
      step();
    end
    for (int ln = 0; ln < r.nlines; ln++) begin
      len = (ln == r.odd_line) ? r.odd_len : TW;
      for (int x = 0; x < len; x++) begin
        active = 1'b1;
        {red, grn, blu} = pat(ln, x);
        step();
        if (r.vs_de && ln == 0 && x == 0) vs_cyc = cyc;
        if (ln == 0 && x == 1) vsync = 1'b1;
        if (ln == r.rst_line && x == 3) begin
          rst_n = 1'b0;
          step();
          rst_n = 1'b1;
          chk("reset_mid_line_outputs", int'({we, frame, locked, line_len, waddr, wdata}), 0);
        end
      end
      active = 1'b0;
      if (ln == 0) enable = 1'b1;
      step();
      hsync = 1'b0;
      step();
      step();
      hsync = 1'b1;
      step();
    end
    repeat (4) step();
    chk("frame_seen", frame_seen, 1);
    chk("frame_latency", frame_cyc - vs_cyc, 1);
    chk("locked_at_vs", lock_at_frame, int'(r.lock_start));
    chk("write_count", wr_cnt, r.writes);
    if (r.writes > 0) chk("max_waddr", max_addr, r.max_addr);
    chk("line_len", int'(line_len), r.len_last);
  endtask

  initial begin
    //          en    vs_de nl odd len rst lock  wr  max ll
    tbl[0]  = '{1'b1, 1'b0, 4, -1, 0, -1, 1'b0, 32, 31, 8};
    tbl[1]  = '{1'b1, 1'b0, 4, -1, 0, -1, 1'b0, 32, 31, 8};
    tbl[2]  = '{1'b1, 1'b0, 4, -1, 0, -1, 1'b1, 32, 31, 8};
    tbl[3]  = '{1'b1, 1'b0, 4,  3, 9, -1, 1'b1, 32, 31, 9};  // long last line
    tbl[4]  = '{1'b1, 1'b0, 4, -1, 0, -1, 1'b0, 32, 31, 8};
    tbl[5]  = '{1'b1, 1'b1, 4, -1, 0, -1, 1'b0, 32, 31, 8};  // vsync with first pixel
    tbl[6]  = '{1'b1, 1'b0, 4,  2, 6, -1, 1'b1, 30, 31, 8};  // short line 2
    tbl[7]  = '{1'b1, 1'b0, 4, -1, 0, -1, 1'b0, 32, 31, 8};
    tbl[8]  = '{1'b1, 1'b0, 6, -1, 0, -1, 1'b0, 32, 31, 8};  // too many lines
    tbl[9]  = '{1'b1, 1'b0, 2, -1, 0, -1, 1'b0, 16, 15, 8};  // early vsync
    tbl[10] = '{1'b0, 1'b0, 4, -1, 0, -1, 1'b0,  0,  0, 8};  // enable raised mid-frame
    tbl[11] = '{1'b1, 1'b0, 4, -1, 0, -1, 1'b0, 32, 31, 8};
    tbl[12] = '{1'b1, 1'b0, 4, -1, 0, -1, 1'b1, 32, 31, 8};
    tbl[13] = '{1'b1, 1'b0, 4, -1, 0,  1, 1'b1, 11, 10, 0};  // reset in line 1
    tbl[14] = '{1'b1, 1'b0, 4, -1, 0, -1, 1'b0, 32, 31, 8};
    tbl[15] = '{1'b1, 1'b0, 4, -1, 0, -1, 1'b0, 32, 31, 8};
    tbl[16] = '{1'b1, 1'b0, 4, -1, 0, -1, 1'b1, 32, 31, 8};

    rst_n = 1'b0;
    repeat (3) step();
    chk("reset_outputs", int'({we, frame, locked, line_len, waddr, wdata}), 0);
    rst_n = 1'b1;
    step();
    chk("idle_no_frame", int'(frame), 0);

    for (int i = 0; i < 17; i++) begin
      drive_frame(tbl[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
